bitstreamer_multi: RTL

- Multi-channel successor to the single-channel antenna-modulation bitstreamer.
- Streams up to DATALEN bits per channel on NCH parallel channels. Each channel has its own start delay (phase delay).
- Bit period, stream length, modulation mode and loop mode are set at run time.
- Sits between the control/register interface and the antenna driver pads; one instance drives a whole antenna array.

---
 rtl/bitstreamer_multi.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bitstreamer_multi.sv
// Multi-channel modulated bitstreamer: NCH phase-delayed streams share one run-time config,
// each with its own carrier, OOK/BPSK modulation and optional seamless looping.
module bitstreamer_multi #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DATALEN = 64,
  parameter int unsigned CNTLEN  = 8,
  parameter int unsigned DIVLEN  = 8,
  parameter int unsigned NBLEN   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*DATALEN-1:0] datain,
  input  logic [NCH*CNTLEN-1:0]  phase_delay,
  input  logic [NBLEN-1:0]       nbits,
  input  logic [DIVLEN-1:0]      bit_div,
  input  logic [DIVLEN-1:0]      car_half,
  input  logic                   mode,
  input  logic                   loop,
  input  logic                   start,
  input  logic                   stop,
  output logic [NCH-1:0]         out,
  output logic [NCH-1:0]         bitout,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {StIdle, StRun} top_e;
  typedef enum logic [1:0] {ChWait, ChStream, ChFin} ch_e;

  localparam logic [NBLEN-1:0]  NbMax  = NBLEN'(DATALEN);
  localparam logic [NBLEN-1:0]  NbOne  = NBLEN'(1);
  localparam logic [DIVLEN-1:0] DivOne = DIVLEN'(1);
  localparam logic [CNTLEN-1:0] DlyOne = CNTLEN'(1);

  top_e              top_q, top_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NBLEN-1:0]  nbits_q, nbits_d;
  logic [DIVLEN-1:0] bdiv_q, bdiv_d;
  logic [DIVLEN-1:0] chalf_q, chalf_d;
  logic              mode_q, mode_d;
  logic              loop_q, loop_d;

  logic [DATALEN-1:0] data_q  [NCH];
  logic [DATALEN-1:0] data_d  [NCH];
  logic [DATALEN-1:0] shift_q [NCH];
  logic [DATALEN-1:0] shift_d [NCH];
  ch_e                ch_q    [NCH];
  ch_e                ch_d    [NCH];
  logic [CNTLEN-1:0]  dly_q   [NCH];
  logic [CNTLEN-1:0]  dly_d   [NCH];
  logic [NBLEN-1:0]   bcnt_q  [NCH];
  logic [NBLEN-1:0]   bcnt_d  [NCH];
  logic [DIVLEN-1:0]  div_q   [NCH];
  logic [DIVLEN-1:0]  div_d   [NCH];
  logic [DIVLEN-1:0]  ccnt_q  [NCH];
  logic [DIVLEN-1:0]  ccnt_d  [NCH];
  logic [NCH-1:0]     bit_q, bit_d;
  logic [NCH-1:0]     car_q, car_d;
  logic [NCH-1:0]     out_q, out_d;

  logic               start_go, all_fin, cur_mode;
  logic [NBLEN-1:0]   nb_eff, cur_nb;
  logic [DIVLEN-1:0]  bd_eff, ch_eff, cur_bd, cur_ch;
  logic [NCH-1:0]     ld;
  logic [DATALEN-1:0] cur_data [NCH];

  always_comb begin
    nb_eff   = (nbits > NbMax) ? NbMax : nbits;
    bd_eff   = (bit_div == '0) ? DivOne : bit_div;
    ch_eff   = (car_half == '0) ? DivOne : car_half;
    start_go = (top_q == StIdle) && start && !stop && (nbits != '0);
    // On the accepting edge the live inputs are used; afterwards only the latched copy.
    cur_nb   = start_go ? nb_eff : nbits_q;
    cur_bd   = start_go ? bd_eff : bdiv_q;
    cur_ch   = start_go ? ch_eff : chalf_q;
    cur_mode = start_go ? mode : mode_q;

    top_d   = top_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nbits_d = nbits_q;
    bdiv_d  = bdiv_q;
    chalf_d = chalf_q;
    mode_d  = mode_q;
    loop_d  = loop_q;
    bit_d   = bit_q;
    car_d   = car_q;
    out_d   = '0;
    ld      = '0;
    all_fin = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      cur_data[c] = start_go ? datain[c*DATALEN +: DATALEN] : data_q[c];
      data_d[c]   = data_q[c];
      shift_d[c]  = shift_q[c];
      ch_d[c]     = ch_q[c];
      dly_d[c]    = dly_q[c];
      bcnt_d[c]   = bcnt_q[c];
      div_d[c]    = div_q[c];
      ccnt_d[c]   = ccnt_q[c];
    end

    if (start_go) begin
      top_d   = StRun;
      busy_d  = 1'b1;
      nbits_d = nb_eff;
      bdiv_d  = bd_eff;
      chalf_d = ch_eff;
      mode_d  = mode;
      loop_d  = loop;
      for (int c = 0; c < NCH; c++) begin
        data_d[c] = cur_data[c];
        if (phase_delay[c*CNTLEN +: CNTLEN] == '0) begin
          ld[c] = 1'b1;
        end else begin
          ch_d[c]  = ChWait;
          dly_d[c] = phase_delay[c*CNTLEN +: CNTLEN] - DlyOne;
        end
      end
    end else if (top_q == StRun) begin
      if (stop) begin
        top_d  = StIdle;
        busy_d = 1'b0;
        bit_d  = '0;
        car_d  = '0;
        for (int c = 0; c < NCH; c++) ch_d[c] = ChFin;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          unique case (ch_q[c])
            ChWait: begin
              if (dly_q[c] == '0) ld[c] = 1'b1;
              else dly_d[c] = dly_q[c] - DlyOne;
            end
            ChStream: begin
              if (ccnt_q[c] == '0) begin
                car_d[c]  = ~car_q[c];
                ccnt_d[c] = cur_ch - DivOne;
              end else begin
                ccnt_d[c] = ccnt_q[c] - DivOne;
              end
              if (div_q[c] != '0) begin
                div_d[c] = div_q[c] - DivOne;
              end else if (bcnt_q[c] != '0) begin
                bit_d[c]   = shift_q[c][0];
                shift_d[c] = shift_q[c] >> 1;
                bcnt_d[c]  = bcnt_q[c] - NbOne;
                div_d[c]   = cur_bd - DivOne;
              end else if (loop_q) begin
                // Seamless wrap: carrier phase keeps running across the restart.
                bit_d[c]   = data_q[c][0];
                shift_d[c] = data_q[c] >> 1;
                bcnt_d[c]  = cur_nb - NbOne;
                div_d[c]   = cur_bd - DivOne;
              end else begin
                ch_d[c]  = ChFin;
                bit_d[c] = 1'b0;
                car_d[c] = 1'b0;
              end
            end
            ChFin: ;
            default: ch_d[c] = ChFin;
          endcase
        end
      end
    end

    for (int c = 0; c < NCH; c++) begin
      if (ld[c]) begin
        ch_d[c]    = ChStream;
        bit_d[c]   = cur_data[c][0];
        shift_d[c] = cur_data[c] >> 1;
        bcnt_d[c]  = cur_nb - NbOne;
        div_d[c]   = cur_bd - DivOne;
        car_d[c]   = 1'b1;
        ccnt_d[c]  = cur_ch - DivOne;
      end
      if (ch_d[c] != ChFin) all_fin = 1'b0;
    end

    if ((top_q == StRun) && !stop && all_fin) begin
      top_d  = StIdle;
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    for (int c = 0; c < NCH; c++) begin
      out_d[c] = cur_mode ? (bit_d[c] ^ car_d[c]) : (bit_d[c] & car_d[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q   <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nbits_q <= '0;
      bdiv_q  <= '0;
      chalf_q <= '0;
      mode_q  <= 1'b0;
      loop_q  <= 1'b0;
      bit_q   <= '0;
      car_q   <= '0;
      out_q   <= '0;
      for (int c = 0; c < NCH; c++) begin
        data_q[c]  <= '0;
        shift_q[c] <= '0;
        ch_q[c]    <= ChFin;
        dly_q[c]   <= '0;
        bcnt_q[c]  <= '0;
        div_q[c]   <= '0;
        ccnt_q[c]  <= '0;
      end
    end else begin
      top_q   <= top_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nbits_q <= nbits_d;
      bdiv_q  <= bdiv_d;
      chalf_q <= chalf_d;
      mode_q  <= mode_d;
      loop_q  <= loop_d;
      bit_q   <= bit_d;
      car_q   <= car_d;
      out_q   <= out_d;
      for (int c = 0; c < NCH; c++) begin
        data_q[c]  <= data_d[c];
        shift_q[c] <= shift_d[c];
        ch_q[c]    <= ch_d[c];
        dly_q[c]   <= dly_d[c];
        bcnt_q[c]  <= bcnt_d[c];
        div_q[c]   <= div_d[c];
        ccnt_q[c]  <= ccnt_d[c];
      end
    end
  end

  assign out    = out_q;
  assign bitout = bit_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
